tmds_decoder: RTL and testbench
===============================

TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 Parameter RUN_LEN, default 8: consecutive control tokens needed to qualify a blanking run.
REQ-002 Parameter HUNT_WINDOW, default 2048: cycles allowed per slip position before advancing.
REQ-003 Parameter LOCK_TIMEOUT, default 4096: cycles without a qualifying run before lock is dropped.
REQ-004 clk_in  input  1  pixel-rate clock; the only clock.
REQ-005 rst_in  input  1  asynchronous, active-high reset.
REQ-006 tmds_in  input  10  raw deserialized TMDS word, one per clk_in, possibly bit-misaligned.
REQ-007 data_out  output  8  decoded pixel byte.
REQ-008 control_out  output  2  last decoded control pair; bit0 = hsync, bit1 = vsync on the blue channel.
REQ-009 ve_out  output  1  video-enable: current output is a data symbol and the block is locked.
REQ-010 locked_out  output  1  word alignment achieved.
REQ-011 slip_out  output  4  current bit rotation, 0..9.

Function
REQ-012 Alignment: register the previous tmds_in as prev; aligned word = bits [slip+9 : slip] of {tmds_in, prev}; slip 0 selects prev.
REQ-013 Control tokens on the aligned word: 10'b1101010100 -> 00, 10'b0010101011 -> 01, 10'b0101010100 -> 10, 10'b1010101011 -> 11.
REQ-014 Data decode for any non-token word q: d = q[9] ? ~q[7:0] : q[7:0]; out[0] = d[0].
REQ-015 Data decode, remaining bits: for i = 1..7, out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
REQ-016 Outputs are registered; latency from tmds_in to data_out/control_out/ve_out is exactly 2 clk_in cycles.
REQ-017 On a token: data_out = 0, control_out = token value, ve_out = 0.
REQ-018 On a data word: data_out = decoded byte, control_out holds its previous value, ve_out = locked.
REQ-019 Decoding runs in every state; only ve_out is gated by lock.
REQ-020 Run counter: increments on each aligned token, clears on any data word, saturates at RUN_LEN; a qualifying run occurs on the cycle it reaches RUN_LEN.
REQ-021 FSM has two states, HUNT and LOCKED; locked_out = 1 only in LOCKED.
REQ-022 HUNT: window counter increments every cycle; a qualifying run moves the FSM to LOCKED and clears the window counter.
REQ-023 HUNT: at window count HUNT_WINDOW-1 with no qualifying run, slip advances (9 wraps to 0) and both window and run counters clear.
REQ-024 A new slip value takes effect on the cycle after the slip decision.
REQ-025 A qualifying run and window expiry in the same cycle resolve to LOCKED with no slip.
REQ-026 LOCKED: timeout counter increments every cycle and clears on each qualifying run, including a saturated run continuing.
REQ-027 LOCKED: at timeout count LOCK_TIMEOUT-1, return to HUNT with slip unchanged and all counters cleared.
REQ-028 slip never changes while in LOCKED.

Reset
REQ-029 While rst_in is high, asynchronously: data_out = 0, control_out = 0, ve_out = 0, locked_out = 0, slip_out = 0.
REQ-030 While rst_in is high, asynchronously: FSM = HUNT, prev = 0, and the run, window and timeout counters = 0.
REQ-031 Reset asserted mid-lock or mid-hunt discards all state; operation resumes from REQ-029/REQ-030 on the first edge after release.

Verification
REQ-032 Aligned stream, 370 tokens 10'b1101010100 then data 10'b0100000000 -> locked_out=1 with slip_out=0; data_out=8'h00, ve_out=1 two cycles after the data word.
REQ-033 tmds_encoder output for a byte sweep 0..255 with syncs toggling, aligned -> data_out matches every input byte and control_out matches {vsync,hsync}, 2-cycle latency.
REQ-034 Same stream rotated by 3 bits -> slip_out steps 0,1,2,3 at HUNT_WINDOW intervals, then lock at slip 3 with error-free bytes thereafter.
REQ-035 Locked, then data-only words for LOCK_TIMEOUT cycles -> locked_out falls at cycle LOCK_TIMEOUT and slip_out stays unchanged.
REQ-036 Slip at 9 with no tokens for a full window -> slip_out wraps to 0; rst_in pulsed while locked -> all outputs 0 immediately, without waiting for a clock edge.
REQ-037 Qualifying run completing on the window-expiry cycle -> LOCKED, slip_out unchanged.

Source files
------------

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: word alignment by bit slipping, control-token detection,
// 8b/10b data decode, and blanking-run based lock tracking.
module tmds_decoder #(
  parameter int RUN_LEN      = 8,
  parameter int HUNT_WINDOW  = 2048,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [9:0] tmds_in,
  output logic [7:0] data_out,
  output logic [1:0] control_out,
  output logic       ve_out,
  output logic       locked_out,
  output logic [3:0] slip_out
);

  localparam int RUN_W = $clog2(RUN_LEN + 1);
  localparam int WIN_W = $clog2(HUNT_WINDOW + 1);
  localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RUN_LEN);
  localparam logic [RUN_W-1:0] RUN_PRE  = RUN_W'(RUN_LEN - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(HUNT_WINDOW - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state;
  logic [9:0]       prev;
  logic [RUN_W-1:0] run_cnt;
  logic [WIN_W-1:0] window_cnt;
  logic [TO_W-1:0]  timeout_cnt;

  logic [19:0]      pair;
  logic [9:0]       aligned;
  logic             is_token;
  logic [1:0]       token_val;
  logic [7:0]       d_word;
  logic [7:0]       dec;
  logic             qualify;
  logic [RUN_W-1:0] run_next;

  // The aligned word straddles the previous and current raw words.
  always_comb begin
    pair    = {tmds_in, prev};
    aligned = 10'(pair >> slip_out);
  end

  always_comb begin
    is_token  = 1'b1;
    token_val = 2'd0;
    case (aligned)
      10'b1101010100: token_val = 2'd0;
      10'b0010101011: token_val = 2'd1;
      10'b0101010100: token_val = 2'd2;
      10'b1010101011: token_val = 2'd3;
      default:        is_token  = 1'b0;
    endcase
  end

  always_comb begin
    d_word = aligned[9] ? ~aligned[7:0] : aligned[7:0];
    dec    = '0;
    dec[0] = d_word[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = aligned[8] ? (d_word[i] ^ d_word[i-1]) : ~(d_word[i] ^ d_word[i-1]);
    end
  end

  // A saturated run keeps qualifying on every further token.
  always_comb begin
    qualify  = is_token && (run_cnt >= RUN_PRE);
    run_next = '0;
    if (is_token) begin
      run_next = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= HUNT;
      prev        <= '0;
      run_cnt     <= '0;
      window_cnt  <= '0;
      timeout_cnt <= '0;
      data_out    <= '0;
      control_out <= '0;
      ve_out      <= 1'b0;
      locked_out  <= 1'b0;
      slip_out    <= '0;
    end else begin
      prev    <= tmds_in;
      run_cnt <= run_next;

      if (is_token) begin
        data_out    <= '0;
        control_out <= token_val;
        ve_out      <= 1'b0;
      end else begin
        data_out <= dec;
        ve_out   <= locked_out;
      end

      case (state)
        HUNT: begin
          // A run on the expiry cycle wins over slipping.
          if (qualify) begin
            state       <= LOCKED;
            locked_out  <= 1'b1;
            window_cnt  <= '0;
            timeout_cnt <= '0;
          end else if (window_cnt == WIN_LAST) begin
            slip_out   <= (slip_out == 4'd9) ? 4'd0 : slip_out + 4'd1;
            window_cnt <= '0;
            run_cnt    <= '0;
          end else begin
            window_cnt <= window_cnt + 1'b1;
          end
        end
        LOCKED: begin
          if (qualify) begin
            timeout_cnt <= '0;
          end else if (timeout_cnt == TO_LAST) begin
            state       <= HUNT;
            locked_out  <= 1'b0;
            timeout_cnt <= '0;
            window_cnt  <= '0;
            run_cnt     <= '0;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        default: begin
          state      <= HUNT;
          locked_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: reference TMDS encoder builds the streams, a queue
// of expected outputs is compared two cycles after each word is driven.
module tb_tmds_decoder;

  localparam int RUN_LEN = 8;
  localparam int HW      = 256;
  localparam int LT      = 512;

  localparam logic [9:0] TOK0  = 10'b1101010100;
  localparam logic [9:0] DATA0 = 10'b0100000000;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic [9:0] tmds_in = '0;
  logic [7:0] data_out;
  logic [1:0] control_out;
  logic       ve_out;
  logic       locked_out;
  logic [3:0] slip_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [9:0] word;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       ve;
  } entry_t;

  entry_t stream[$];
  entry_t sb[$];
  int     enc_cnt;

  tmds_decoder #(
    .RUN_LEN(RUN_LEN), .HUNT_WINDOW(HW), .LOCK_TIMEOUT(LT)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .tmds_in(tmds_in),
    .data_out(data_out), .control_out(control_out), .ve_out(ve_out),
    .locked_out(locked_out), .slip_out(slip_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [9:0] token(input logic [1:0] c);
    case (c)
      2'd0:    return 10'b1101010100;
      2'd1:    return 10'b0010101011;
      2'd2:    return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  // DC-balanced TMDS encoding with running disparity in enc_cnt.
  task automatic encode(input logic [7:0] d, output logic [9:0] q);
    logic [8:0] qm;
    int n1, n1q, n0q;
    n1 = $countones(d);
    qm = '0;
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_cnt == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      if (qm[8]) enc_cnt = enc_cnt + n1q - n0q;
      else       enc_cnt = enc_cnt + n0q - n1q;
    end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt = enc_cnt + (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_cnt = enc_cnt - (qm[8] ? 0 : 2) + n1q - n0q;
    end
  endtask

  task automatic build_stream();
    entry_t e;
    logic [1:0] c_hold;
    logic [9:0] q;
    c_hold = 2'd0;
    enc_cnt = 0;
    for (int b = 0; b < 256; b++) begin
      if (b % 16 == 0) begin
        c_hold  = 2'(b / 16);
        enc_cnt = 0;
        for (int t = 0; t < 12; t++) begin
          e.word = token(c_hold); e.data = 8'h00; e.ctrl = c_hold; e.ve = 1'b0;
          stream.push_back(e);
        end
      end
      encode(8'(b), q);
      e.word = q; e.data = 8'(b); e.ctrl = c_hold; e.ve = 1'b1;
      stream.push_back(e);
    end
  endtask

  // Raw words carrying the stream three bits late, so slip 3 realigns them.
  function automatic logic [9:0] rot_word(input int k);
    int n;
    logic [9:0] cur, prv;
    n   = stream.size();
    cur = stream[k % n].word;
    prv = stream[(k + n - 1) % n].word;
    return {cur[6:0], prv[9:7]};
  endfunction

  task automatic step(input logic [9:0] w);
    tmds_in = w;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    tmds_in = '0;
    rst_in  = 1'b1;
    #3;
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_in = 1'b1;
    #1;
    total++; if (data_out !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h want=00", data_out); end
    total++; if (control_out !== 2'd0) begin bad++; $display("[TB] FAIL reset_ctrl got=%0d want=0", control_out); end
    total++; if (ve_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_ve got=%b want=0", ve_out); end
    total++; if (locked_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_locked got=%b want=0", locked_out); end
    total++; if (slip_out !== 4'd0) begin bad++; $display("[TB] FAIL reset_slip got=%0d want=0", slip_out); end
  endtask

  task automatic test_aligned_lock();
    do_reset();
    repeat (370) step(TOK0);
    total++; if (locked_out !== 1'b1) begin bad++; $display("[TB] FAIL lock_locked got=%b want=1", locked_out); end
    total++; if (slip_out !== 4'd0) begin bad++; $display("[TB] FAIL lock_slip got=%0d want=0", slip_out); end
    step(DATA0);
    total++; if (ve_out !== 1'b0) begin bad++; $display("[TB] FAIL lock_ve_early got=%b want=0", ve_out); end
    step(TOK0);
    total++; if (data_out !== 8'h00) begin bad++; $display("[TB] FAIL lock_data got=%h want=00", data_out); end
    total++; if (ve_out !== 1'b1) begin bad++; $display("[TB] FAIL lock_ve got=%b want=1", ve_out); end
    total++; if (control_out !== 2'd0) begin bad++; $display("[TB] FAIL lock_ctrl got=%0d want=0", control_out); end
  endtask

  task automatic test_timeout();
    repeat (10) step(TOK0);
    for (int n = 1; n <= LT + 2; n++) begin
      step(DATA0);
      if (n == LT) begin
        total++; if (locked_out !== 1'b1) begin bad++; $display("[TB] FAIL timeout_hold got=%b want=1", locked_out); end
        total++; if (ve_out !== 1'b1) begin bad++; $display("[TB] FAIL timeout_ve_hold got=%b want=1", ve_out); end
      end
      if (n == LT + 1) begin
        total++; if (locked_out !== 1'b0) begin bad++; $display("[TB] FAIL timeout_drop got=%b want=0", locked_out); end
        total++; if (slip_out !== 4'd0) begin bad++; $display("[TB] FAIL timeout_slip got=%0d want=0", slip_out); end
      end
      if (n == LT + 2) begin
        total++; if (ve_out !== 1'b0) begin bad++; $display("[TB] FAIL timeout_ve got=%b want=0", ve_out); end
      end
    end
  endtask

  task automatic test_sweep();
    entry_t e;
    int n;
    n = stream.size();
    do_reset();
    sb.delete();
    for (int k = 0; k <= n; k++) begin
      if (k < n) sb.push_back(stream[k]);
      step(k < n ? stream[k].word : token(2'd0));
      if (k >= 1) begin
        e = sb.pop_front();
        total++; if (data_out !== e.data) begin bad++; $display("[TB] FAIL sweep_data k=%0d got=%h want=%h", k - 1, data_out, e.data); end
        total++; if (control_out !== e.ctrl) begin bad++; $display("[TB] FAIL sweep_ctrl k=%0d got=%0d want=%0d", k - 1, control_out, e.ctrl); end
        total++; if (ve_out !== e.ve) begin bad++; $display("[TB] FAIL sweep_ve k=%0d got=%b want=%b", k - 1, ve_out, e.ve); end
      end
    end
  endtask

  task automatic test_rotated();
    entry_t e;
    int n, idx, cyc;
    n   = stream.size();
    idx = 0;
    cyc = 0;
    do_reset();
    while (locked_out !== 1'b1 && cyc < 4 * HW) begin
      step(rot_word(idx));
      idx = (idx + 1) % n;
      cyc++;
      if (cyc == HW - 1 || cyc == HW || cyc == 2 * HW - 1 || cyc == 2 * HW ||
          cyc == 3 * HW - 1 || cyc == 3 * HW) begin
        total++;
        if (slip_out !== 4'(cyc / HW)) begin
          bad++; $display("[TB] FAIL rot_slip cyc=%0d got=%0d want=%0d", cyc, slip_out, cyc / HW);
        end
      end
    end
    total++; if (locked_out !== 1'b1) begin bad++; $display("[TB] FAIL rot_lock got=%b want=1 after %0d cycles", locked_out, cyc); end
    total++; if (slip_out !== 4'd3) begin bad++; $display("[TB] FAIL rot_lock_slip got=%0d want=3", slip_out); end
    while (idx != 0) begin
      step(rot_word(idx));
      idx = (idx + 1) % n;
    end
    sb.delete();
    for (int k = 0; k <= n; k++) begin
      if (k < n) sb.push_back(stream[k]);
      step(rot_word(k));
      if (k >= 1) begin
        e = sb.pop_front();
        total++; if (data_out !== e.data) begin bad++; $display("[TB] FAIL rot_data k=%0d got=%h want=%h", k - 1, data_out, e.data); end
        total++; if (control_out !== e.ctrl) begin bad++; $display("[TB] FAIL rot_ctrl k=%0d got=%0d want=%0d", k - 1, control_out, e.ctrl); end
        total++; if (ve_out !== e.ve) begin bad++; $display("[TB] FAIL rot_ve k=%0d got=%b want=%b", k - 1, ve_out, e.ve); end
      end
    end
  endtask

  task automatic test_reset_while_locked();
    rst_in = 1'b1;
    #1;
    total++; if (data_out !== 8'h00) begin bad++; $display("[TB] FAIL rst_lock_data got=%h want=00", data_out); end
    total++; if (control_out !== 2'd0) begin bad++; $display("[TB] FAIL rst_lock_ctrl got=%0d want=0", control_out); end
    total++; if (ve_out !== 1'b0) begin bad++; $display("[TB] FAIL rst_lock_ve got=%b want=0", ve_out); end
    total++; if (locked_out !== 1'b0) begin bad++; $display("[TB] FAIL rst_lock_locked got=%b want=0", locked_out); end
    total++; if (slip_out !== 4'd0) begin bad++; $display("[TB] FAIL rst_lock_slip got=%0d want=0", slip_out); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int n = 1; n <= 10 * HW; n++) begin
      step(DATA0);
      if (n == 9 * HW || n == 10 * HW - 1) begin
        total++; if (slip_out !== 4'd9) begin bad++; $display("[TB] FAIL wrap_nine n=%0d got=%0d want=9", n, slip_out); end
      end
      if (n == 10 * HW) begin
        total++; if (slip_out !== 4'd0) begin bad++; $display("[TB] FAIL wrap_zero got=%0d want=0", slip_out); end
      end
    end
  endtask

  task automatic test_run_at_expiry();
    do_reset();
    for (int n = 1; n <= HW + 4; n++) begin
      step((n >= HW - 8 && n <= HW - 1) ? TOK0 : DATA0);
      if (n == HW - 1) begin
        total++; if (locked_out !== 1'b0) begin bad++; $display("[TB] FAIL expiry_early got=%b want=0", locked_out); end
      end
      if (n == HW) begin
        total++; if (locked_out !== 1'b1) begin bad++; $display("[TB] FAIL expiry_lock got=%b want=1", locked_out); end
        total++; if (slip_out !== 4'd0) begin bad++; $display("[TB] FAIL expiry_slip got=%0d want=0", slip_out); end
      end
    end
  endtask

  initial begin
    $display("[TB] tmds_decoder bench start");
    build_stream();
    test_reset();
    test_aligned_lock();
    test_timeout();
    test_sweep();
    test_rotated();
    test_reset_while_locked();
    test_wrap();
    test_run_at_expiry();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
